seq_div: RTL and testbench

- Sequential restoring divider; the inverse of the team's sequential multiplier (seq_mul).
- Takes an N-bit dividend and an M-bit divisor on a start pulse.
- Produces one quotient bit per clock, then an N-bit quotient and an M-bit remainder with a one-cycle done pulse.
- Used to check and undo multiplier products, e.g. op / b = a.

---
 rtl/seq_div.sv | 128 ++++++++++++
 tb/tb_seq_div.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_div.sv
// Sequential restoring divider: one quotient bit per clock, N cycles per result.
// A zero divisor short-circuits straight to a flagged result.
module seq_div #(
    parameter int unsigned N = 8,  // dividend / quotient width
    parameter int unsigned M = 4   // divisor / remainder width, M <= N
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [M-1:0] divisor,
    output logic [N-1:0] quot,
    output logic [M-1:0] rem,
    output logic         busy,
    output logic         done,
    output logic         dz
);

    localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StFin,
        StHold
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [M:0]      p_q, p_d;      // partial remainder
    logic [N-1:0]    q_q, q_d;      // shifting dividend / developing quotient
    logic [M-1:0]    div_q, div_d;
    logic [N-1:0]    quot_q, quot_d;
    logic [M-1:0]    rem_q, rem_d;
    logic            dz_q, dz_d;

    logic [M+1:0]    p_sh;          // top bit is always zero; kept so the sign is clean
    logic [M+1:0]    diff;
    logic [M:0]      p_nxt;
    logic [N-1:0]    q_nxt;
    logic            accept;

    // Next-state: request acceptance, one restoring step per RUN cycle, result write.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        p_d     = p_q;
        q_d     = q_q;
        div_d   = div_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dz_d    = dz_q;

        p_sh   = {p_q, q_q[N-1]};
        diff   = p_sh - {2'b00, div_q};
        p_nxt  = diff[M+1] ? p_sh[M:0] : diff[M:0];
        q_nxt  = (q_q << 1) | N'(!diff[M+1]);
        accept = start && (state_q != StRun);

        unique case (state_q)
            StRun: begin
                p_d = p_nxt;
                q_d = q_nxt;
                if (cnt_q == '0) begin
                    quot_d  = q_nxt;
                    rem_d   = p_nxt[M-1:0];
                    state_d = StFin;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StFin:   state_d = StHold;
            StIdle,
            StHold:  state_d = state_q;
            default: state_d = StIdle;
        endcase

        if (accept) begin
            div_d = divisor;
            dz_d  = 1'b0;
            if (divisor == '0) begin
                // Nothing to iterate: publish the flagged result right away.
                quot_d  = '1;
                rem_d   = dividend[M-1:0];
                dz_d    = 1'b1;
                state_d = StFin;
            end else begin
                cnt_d   = CntW'(N - 1);
                p_d     = '0;
                q_d     = dividend;
                state_d = StRun;
            end
        end
    end

    // State and datapath registers; reset aborts any division in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            p_q     <= '0;
            q_q     <= '0;
            div_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
            q_q     <= q_d;
            div_q   <= div_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dz_q    <= dz_d;
        end
    end

    // Outputs decoded from state and result registers.
    always_comb begin
        busy = (state_q == StRun);
        done = (state_q == StFin);
        quot = quot_q;
        rem  = rem_q;
        dz   = dz_q;
    end

endmodule

// File: tb/tb_seq_div.sv
// Self-checking bench for seq_div: arithmetic reference model checked every cycle,
// plus directed divisions with hand-computed results.
module tb_seq_div;

    localparam int unsigned N = 8;
    localparam int unsigned M = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         start = 1'b0;
    logic [N-1:0] dividend = '0;
    logic [M-1:0] divisor = '0;
    logic [N-1:0] quot;
    logic [M-1:0] rem;
    logic         busy;
    logic         done;
    logic         dz;

    int checks = 0;
    int errors = 0;

    seq_div #(.N(N), .M(M)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .dividend (dividend),
        .divisor  (divisor),
        .quot     (quot),
        .rem      (rem),
        .busy     (busy),
        .done     (done),
        .dz       (dz)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: results from plain / and %, timing as a cycle countdown.
    int m_left = 0;
    bit m_done = 1'b0;
    bit m_dz = 1'b0;
    int m_quot = 0;
    int m_rem = 0;
    int m_pq = 0;
    int m_pr = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_left <= 0;
            m_done <= 1'b0;
            m_dz   <= 1'b0;
            m_quot <= 0;
            m_rem  <= 0;
        end else begin
            m_done <= 1'b0;
            if (m_left > 0) begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    m_done <= 1'b1;
                    m_quot <= m_pq;
                    m_rem  <= m_pr;
                end
            end else if (start) begin
                if (divisor == 0) begin
                    m_done <= 1'b1;
                    m_dz   <= 1'b1;
                    m_quot <= (1 << N) - 1;
                    m_rem  <= int'(dividend) % (1 << M);
                end else begin
                    m_left <= N;
                    m_dz   <= 1'b0;
                    m_pq   <= int'(dividend) / int'(divisor);
                    m_pr   <= int'(dividend) % int'(divisor);
                end
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        check("busy", int'(busy), int'(m_left > 0));
        check("done", int'(done), int'(m_done));
        check("quot", int'(quot), m_quot);
        check("rem", int'(rem), m_rem);
        check("dz", int'(dz), int'(m_dz));
    end

    // Issue one request at a negedge and wait (bounded) for done.
    task automatic run_div(input int a, input int b, input int eq, input int er,
                           input int edz, input int elat, input int ebusy);
        int lat  = 0;
        int bcnt = 0;
        bit got  = 1'b0;
        dividend = N'(a);
        divisor  = M'(b);
        start    = 1'b1;
        while (!got && lat < 40) begin
            @(negedge clk);
            lat++;
            start = 1'b0;
            if (busy) bcnt++;
            if (done) got = 1'b1;
        end
        check("done_seen", int'(got), 1);
        check("latency", lat, elat);
        check("busy_cycles", bcnt, ebusy);
        check("res_quot", int'(quot), eq);
        check("res_rem", int'(rem), er);
        check("res_dz", int'(dz), edz);
    endtask

    initial begin
        int  cyc;
        bit  got;
        rst = 1'b1;
        repeat (10) @(negedge clk);
        check("rst_quot", int'(quot), 0);
        check("rst_rem", int'(rem), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_dz", int'(dz), 0);
        rst = 1'b0;

        run_div(117, 13, 9, 0, 0, 9, 8);
        repeat (3) @(negedge clk);

        // Back-to-back: second request raised in the FIN cycle of the first.
        run_div(200, 7, 28, 4, 0, 9, 8);
        run_div(255, 1, 255, 0, 0, 9, 8);
        repeat (2) @(negedge clk);

        run_div(5, 15, 0, 5, 0, 9, 8);
        run_div(143, 9, 15, 8, 0, 9, 8);

        // Divide by zero, then a valid division clears the flag.
        run_div(100, 0, 255, 4, 1, 1, 0);
        run_div(99, 10, 9, 9, 0, 9, 8);
        repeat (2) @(negedge clk);

        // Starts raised while iterating must be ignored.
        dividend = 8'd117;
        divisor  = 4'd13;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        dividend = 8'd50;
        divisor  = 4'd5;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 6;
        got = done;
        while (!got && cyc < 30) begin
            @(negedge clk);
            cyc++;
            got = done;
        end
        check("ign_done_seen", int'(got), 1);
        check("ign_latency", cyc, 9);
        check("ign_quot", int'(quot), 9);
        check("ign_rem", int'(rem), 0);

        // Reset in the middle of a new division aborts it.
        dividend = 8'd200;
        divisor  = 4'd7;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("abort_done", int'(done), 0);
            check("abort_busy", int'(busy), 0);
        end
        check("abort_quot", int'(quot), 0);
        check("abort_rem", int'(rem), 0);
        check("abort_dz", int'(dz), 0);
        rst = 1'b0;
        run_div(60, 7, 8, 4, 0, 9, 8);
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
